flash_ctrl: RTL and testbench

Synchronous master for the board's parallel NOR flash. Converts a single-cycle request/acknowledge interface from the score-board logic into correctly timed NF_CE/NF_OE/NF_WE strobe sequences, drives NF_A, owns the bidirectional NF_D bus, and returns read data. Sits directly upstream of the flash device (or the flash simulation model in benches), with all flash pins wired straight to it.

---
 rtl/flash_pkg.sv | 30 +++
 rtl/flash_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_flash_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/flash_pkg.sv
// Shared types and defaults for the parallel NOR flash controller.
package flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_HOLD     = 3'd3,
    ST_STS_WAIT = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned DEF_ADDR_W      = 8;
  localparam int unsigned DEF_T_SETUP     = 1;
  localparam int unsigned DEF_T_RD        = 6;
  localparam int unsigned DEF_T_WP        = 4;
  localparam int unsigned DEF_T_HOLD      = 1;
  localparam int unsigned DEF_STS_TIMEOUT = 4095;

  // Static pin levels: byte mode, device out of reset, writes enabled.
  localparam logic NF_BYTE_TIE = 1'b0;
  localparam logic NF_RP_TIE   = 1'b1;
  localparam logic NF_WP_TIE   = 1'b1;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flash_ctrl.sv
// Request/ack master generating timed CE/OE/WE strobe sequences for a parallel NOR flash.
// Optional FLASH_CTRL_STS_WAIT_EN: after writes, wait on synchronised NF_STS with timeout.
module flash_ctrl
  import flash_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned T_SETUP     = DEF_T_SETUP,
  parameter int unsigned T_RD        = DEF_T_RD,
  parameter int unsigned T_WP        = DEF_T_WP,
  parameter int unsigned T_HOLD      = DEF_T_HOLD,
  parameter int unsigned STS_TIMEOUT = DEF_STS_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              ack,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W-1:0] NF_A,
  inout  wire  [DATA_W-1:0] NF_D,
  output logic              NF_CE,
  output logic              NF_OE,
  output logic              NF_WE,
  output logic              NF_BYTE,
  output logic              NF_RP,
  output logic              NF_WP,
  input  logic              NF_STS
);

`ifdef FLASH_CTRL_STS_WAIT_EN
  localparam int unsigned CNT_MAX = max2(max2(max2(T_SETUP, T_RD), max2(T_WP, T_HOLD)),
                                         STS_TIMEOUT);
`else
  localparam int unsigned CNT_MAX = max2(max2(T_SETUP, T_RD), max2(T_WP, T_HOLD));
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_cnt_zero;

  logic                r_we;
  logic                w_we_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   r_dout;
  logic [DATA_W-1:0]   w_dout_nxt;
  logic [DATA_W-1:0]   r_rd_data;
  logic [DATA_W-1:0]   w_rd_data_nxt;
  logic                r_ce;
  logic                w_ce_nxt;
  logic                r_oe;
  logic                w_oe_nxt;
  logic                r_wen;
  logic                w_wen_nxt;
  logic                r_doe;
  logic                w_doe_nxt;
  logic                r_ack;
  logic                w_ack_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_err;
  logic                w_err_nxt;

  assign w_cnt_zero = (r_cnt == '0);

`ifdef FLASH_CTRL_STS_WAIT_EN
  // NF_STS is asynchronous to clk; two flops before the FSM looks at it.
  logic r_sts_meta;
  logic r_sts_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sts_meta <= 1'b0;
      r_sts_sync <= 1'b0;
    end else begin
      r_sts_meta <= NF_STS;
      r_sts_sync <= r_sts_meta;
    end
  end
`else
  logic w_sts_unused;
  assign w_sts_unused = NF_STS ^ 1'(STS_TIMEOUT);
`endif

  // State, counter and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_dout    <= '0;
      r_rd_data <= '0;
      r_ce      <= 1'b1;
      r_oe      <= 1'b1;
      r_wen     <= 1'b1;
      r_doe     <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_we      <= w_we_nxt;
      r_addr    <= w_addr_nxt;
      r_dout    <= w_dout_nxt;
      r_rd_data <= w_rd_data_nxt;
      r_ce      <= w_ce_nxt;
      r_oe      <= w_oe_nxt;
      r_wen     <= w_wen_nxt;
      r_doe     <= w_doe_nxt;
      r_ack     <= w_ack_nxt;
      r_busy    <= w_busy_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Next state; the shared counter is loaded with (T_x - 1) on each state entry.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = CNT_W'(T_SETUP - 1);
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = r_we ? CNT_W'(T_WP - 1) : CNT_W'(T_RD - 1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = CNT_W'(T_HOLD - 1);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
`ifdef FLASH_CTRL_STS_WAIT_EN
          if (r_we) begin
            w_state_nxt = ST_STS_WAIT;
            w_cnt_nxt   = CNT_W'(STS_TIMEOUT - 1);
          end else begin
            w_state_nxt = ST_DONE;
          end
`else
          w_state_nxt = ST_DONE;
`endif
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
`ifdef FLASH_CTRL_STS_WAIT_EN
      ST_STS_WAIT: begin
        if (r_sts_sync || w_cnt_zero) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
`endif
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs; strobes change only at counter expiry.
  always_comb begin
    w_we_nxt      = r_we;
    w_addr_nxt    = r_addr;
    w_dout_nxt    = r_dout;
    w_rd_data_nxt = r_rd_data;
    w_ce_nxt      = r_ce;
    w_oe_nxt      = r_oe;
    w_wen_nxt     = r_wen;
    w_doe_nxt     = r_doe;
    w_busy_nxt    = r_busy;
    w_ack_nxt     = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          w_we_nxt   = we;
          w_addr_nxt = addr;
          w_dout_nxt = wr_data;
          w_ce_nxt   = 1'b0;
          w_doe_nxt  = we;
          w_busy_nxt = 1'b1;
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          w_wen_nxt = ~r_we;
          w_oe_nxt  = r_we;
        end
      end
      ST_STROBE: begin
        if (w_cnt_zero) begin
          w_oe_nxt  = 1'b1;
          w_wen_nxt = 1'b1;
          if (!r_we) begin
            w_rd_data_nxt = NF_D;
          end
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_ce_nxt  = 1'b1;
          w_doe_nxt = 1'b0;
          w_ack_nxt = (w_state_nxt == ST_DONE);
        end
      end
`ifdef FLASH_CTRL_STS_WAIT_EN
      ST_STS_WAIT: begin
        if (r_sts_sync || w_cnt_zero) begin
          w_ack_nxt = 1'b1;
          w_err_nxt = ~r_sts_sync;
        end
      end
`endif
      ST_DONE: begin
        w_busy_nxt = 1'b0;
      end
      default: begin
      end
    endcase
  end

  assign rd_data = r_rd_data;
  assign ack     = r_ack;
  assign busy    = r_busy;
  assign err     = r_err;
  assign NF_A    = r_addr;
  assign NF_CE   = r_ce;
  assign NF_OE   = r_oe;
  assign NF_WE   = r_wen;
  assign NF_D    = r_doe ? r_dout : {DATA_W{1'bz}};
  assign NF_BYTE = NF_BYTE_TIE;
  assign NF_RP   = NF_RP_TIE;
  assign NF_WP   = NF_WP_TIE;

endmodule

// File: tb/tb_flash_ctrl.sv
// Bench for flash_ctrl: flash device model plus a cycle-timeline reference model of every transfer.
module tb_flash_ctrl;

  localparam int T_SETUP = 1;
  localparam int T_RD    = 6;
  localparam int T_WP    = 4;
  localparam int T_HOLD  = 1;

  logic       clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst     = 1'b1;
  logic       req     = 1'b0;
  logic       we      = 1'b0;
  logic       nf_sts  = 1'b0;
  logic [7:0] addr    = '0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic [7:0] nf_a;
  logic       ack, busy, err, nf_ce, nf_oe, nf_we, nf_byte, nf_rp, nf_wp;
  wire  [7:0] nf_d;

  flash_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .ack(ack), .busy(busy), .err(err),
    .NF_A(nf_a), .NF_D(nf_d), .NF_CE(nf_ce), .NF_OE(nf_oe), .NF_WE(nf_we),
    .NF_BYTE(nf_byte), .NF_RP(nf_rp), .NF_WP(nf_wp), .NF_STS(nf_sts)
  );

  // Flash device: read data becomes valid only in the final cycle of the OE window.
  logic [7:0] fmem [256];
  int         oe_cnt   = 0;
  logic [7:0] f_last_a = '0;
  logic [7:0] f_last_d = '0;
  assign nf_d = (!nf_ce && !nf_oe) ? ((oe_cnt >= T_RD) ? fmem[nf_a] : ~fmem[nf_a]) : 8'hzz;

  // Reference model state
  logic [7:0] gold [256];
  int         cyc = 0;
  logic       m_act = 1'b0;
  int         m_s = 0;
  logic       m_w = 1'b0;
  logic [7:0] m_a = '0;
  logic [7:0] m_d = '0;
  logic [7:0] exp_rd = '0;
  int         ack_cyc = -1;
  int         acc_n = 0;
  int         ce_fall_n = 0;
  int         we_low_n = 0;
  int         oe_low_n = 0;
  logic       prev_ce = 1'b1;
  logic       prev_we = 1'b1;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic int lat(input logic w);
    return T_SETUP + (w ? T_WP : T_RD) + T_HOLD + 1;
  endfunction

  task automatic chk1(input string nm, input logic a, input logic e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] a, input logic [7:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic chki(input string nm, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // One clock cycle: device update, compare against the model, then drive next inputs.
  task automatic step(input logic s_req, input logic s_we, input logic [7:0] s_a,
                      input logic [7:0] s_d, input logic s_rst);
    int   d;
    int   len;
    int   t_str;
    logic live;
    logic e_str;
    @(negedge clk);
    if (!prev_we && nf_we && !nf_ce) begin
      fmem[nf_a] = nf_d;
      f_last_a   = nf_a;
      f_last_d   = nf_d;
    end
    oe_cnt = nf_oe ? 0 : oe_cnt + 1;

    d     = cyc - m_s;
    len   = lat(m_w);
    t_str = m_w ? T_WP : T_RD;
    live  = m_act && (d <= len);
    if (live && !m_w && d == T_SETUP + T_RD + 1) exp_rd = gold[m_a];
    if (live && m_w && d == len) gold[m_a] = m_d;
    e_str = live && (d >= T_SETUP + 1) && (d <= T_SETUP + t_str);

    chk1("busy", busy, live);
    chk1("ack", ack, live && (d == len));
    chk1("nf_ce", nf_ce, !(live && d <= len - 1));
    chk1("nf_oe", nf_oe, !(e_str && !m_w));
    chk1("nf_we", nf_we, !(e_str && m_w));
    chk1("err", err, 1'b0);
    chk8("rd_data", rd_data, exp_rd);
    chk1("nf_byte", nf_byte, 1'b0);
    chk1("nf_rp", nf_rp, 1'b1);
    chk1("nf_wp", nf_wp, 1'b1);
    if (live && d <= len - 1) chk8("nf_a", nf_a, m_a);
    if (live && m_w && d <= len - 1) chk8("nf_d_write", nf_d, m_d);

    if (ack === 1'b1) ack_cyc = cyc;
    if (nf_we === 1'b0) we_low_n++;
    if (nf_oe === 1'b0) oe_low_n++;
    if (prev_ce === 1'b1 && nf_ce === 1'b0) ce_fall_n++;
    prev_ce = nf_ce;
    prev_we = nf_we;

    rst     = s_rst;
    req     = s_req;
    we      = s_we;
    addr    = s_a;
    wr_data = s_d;
    nf_sts  = 1'($urandom);
    if (s_rst) begin
      m_act  = 1'b0;
      exp_rd = 8'h00;
    end else if (s_req && !live) begin
      m_act    = 1'b1;
      m_s      = cyc;
      m_w      = s_we;
      m_a      = s_a;
      m_d      = s_d;
      acc_n++;
      we_low_n = 0;
      oe_low_n = 0;
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] dd);
    step(1'b1, w, a, dd, 1'b0);
    while (cyc - m_s <= lat(m_w)) idle();
  endtask

  function automatic logic write_live();
    return m_act && m_w && (cyc - m_s <= lat(m_w));
  endfunction

  initial begin
    int c0;
    int a0;
    for (int i = 0; i < 256; i++) begin
      fmem[i] = 8'($urandom);
      gold[i] = fmem[i];
    end

    repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    idle();
    chk8("reset_nf_a", nf_a, 8'h00);

    xfer(1'b1, 8'h03, 8'hA5);
    chki("wr_ack_latency", ack_cyc - m_s, 7);
    chki("wr_we_low_cycles", we_low_n, 4);
    chki("wr_oe_low_cycles", oe_low_n, 0);
    chk8("dev_write_addr", f_last_a, 8'h03);
    chk8("dev_write_data", f_last_d, 8'hA5);

    xfer(1'b0, 8'h03, 8'h00);
    chki("rd_ack_latency", ack_cyc - m_s, 9);
    chki("rd_oe_low_cycles", oe_low_n, 6);
    chki("rd_we_low_cycles", we_low_n, 0);
    chk8("rd_data_a5", rd_data, 8'hA5);

    xfer(1'b1, 8'h00, 8'h11);
    xfer(1'b1, 8'h01, 8'h22);
    xfer(1'b0, 8'h00, 8'h00);
    chk8("b2b_rd0", rd_data, 8'h11);
    xfer(1'b0, 8'h01, 8'h00);
    chk8("b2b_rd1", rd_data, 8'h22);

    // req held through the whole transfer including the ack cycle
    c0 = ce_fall_n;
    a0 = acc_n;
    step(1'b1, 1'b0, 8'h07, 8'h00, 1'b0);
    repeat (9) step(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
    idle();
    chki("busy_req_ce_falls", ce_fall_n - c0, 1);
    chki("busy_req_accepts", acc_n - a0, 1);

    // reset in the middle of a read
    step(1'b1, 1'b0, 8'h01, 8'h00, 1'b0);
    repeat (4) idle();
    repeat (3) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    repeat (3) idle();
    chk8("rst_mid_rd_data", rd_data, 8'h00);
    chk1("rst_mid_busy", busy, 1'b0);
    xfer(1'b0, 8'h01, 8'h00);
    chk8("post_rst_rd", rd_data, 8'h22);

    for (int i = 0; i < 3000; i++) begin
      logic r_rst;
      r_rst = ($urandom_range(0, 199) == 0) && !write_live();
      step(1'($urandom_range(0, 2) == 0), 1'($urandom), 8'($urandom_range(0, 15)),
           8'($urandom), r_rst);
    end
    repeat (12) idle();

    chki("ce_per_accept", ce_fall_n, acc_n);
    for (int i = 0; i < 16; i++) chk8("dev_mem", fmem[i], gold[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
